atari_bus_initiator: RTL and testbench
======================================

// Module: atari_bus_initiator
// PURPOSE
//  Atari 7800 CPU/MARIA bus-cycle generator: the initiator side of the cart bus our cartridge answers.
//  Turns a request stream (addr/we/wdata/dma) into 6502-style cycles on a, d, phi2, rw and halt.
//  Returns read data or write completion on a response strobe.
//  Lives on the bench/exerciser FPGA that drives the cartridge board.
//  Used for hardware self-test of the ROM and POKEY decode without a console.
// PARAMETERS
//  PHI2_LOW_CYC   7  clk cycles phi2 is low per bus cycle (>=2)
//  PHI2_HIGH_CYC  8  clk cycles phi2 is high per bus cycle (>=SAMPLE_EARLY+2)
//  SAMPLE_EARLY   1  read-data sample point, in clks before the last phi2-high clk
// PORTS
//  clk        in   1   27MHz system clock
//  reset      in   1   asynchronous, active-high reset
//  req_valid  in   1   request present
//  req_ready  out  1   request accepted this clk if req_valid
//  req_addr   in   16  bus address
//  req_we     in   1   1=write cycle (rw=0)
//  req_wdata  in   8   write data
//  req_dma    in   1   1=MARIA DMA read cycle (halt low); forces read
//  rsp_valid  out  1   one-clk pulse: accepted transaction complete
//  rsp_rdata  out  8   sampled read data; holds last read value on writes
//  a          out  16  address bus
//  d_out      out  8   data bus drive value
//  d_oe       out  1   data bus drive enable (to pad tristate)
//  d_in       in   8   data bus sample (from pad)
//  phi2       out  1   phase-2 clock
//  rw         out  1   1=read, 0=write
//  halt       out  1   active-low DMA halt
// BEHAVIOUR
//  - P = PHI2_LOW_CYC+PHI2_HIGH_CYC (15 -> ~1.8MHz). Phase counter pc counts 0..P-1 and wraps; it free-runs.
//  - phi2 = 1 iff pc in [PHI2_LOW_CYC, P-1]. phi2 is registered and glitch-free.
//  - req_ready = (pc==P-1) && !reset. Accept = req_valid && req_ready.
//  - On the accept edge (pc -> 0): a<=req_addr; rw<=~(req_we&~req_dma); halt<=~req_dma; d_out<=req_wdata.
//  - No accept at a cycle boundary gives an idle cycle: a holds its value, rw=1, halt=1, d_oe=0, no response.
//  - Consecutive DMA accepts keep halt low continuously, with no high glitch between cycles.
//  - Write cycle: d_oe=1 for pc in [PHI2_LOW_CYC, P-1] plus pc=0 of the following cycle (one-clk data hold).
//    d_out is stable for the whole cycle.
//  - Read/DMA cycle: d_oe=0. d_in is captured into rsp_rdata on the edge ending pc==P-1-SAMPLE_EARLY.
//  - rsp_valid=1 for exactly one clk, at pc==P-SAMPLE_EARLY of the transaction's bus cycle.
//    This applies to reads, DMA reads and writes.
//  - Accept-to-rsp_valid latency is P clks. Back-to-back requests give 100% bus utilisation.
//  - Simultaneous rsp_valid and req_ready (default SAMPLE_EARLY=1) is legal. The next request may be issued
//    combinationally from the response.
//  - req_dma=1 with req_we=1: the request is executed as a DMA read and req_wdata is ignored.
//  - Reset values: pc=0, phi2=0, a=16'h0000, rw=1, halt=1, d_out=8'h00, d_oe=0,
//    rsp_valid=0, rsp_rdata=8'h00, req_ready=0.
//  - Reset mid-cycle: the in-flight transaction is dropped with no rsp_valid. The bus goes idle immediately.
//    Counting restarts at pc=0 after reset release.
//  - No arithmetic on the address or data; widths pass through unchanged.
// STRUCTURE
//  - Shared package atari_bus_pkg: PHI2_LOW_CYC/PHI2_HIGH_CYC defaults,
//    ROM_BASE=16'h4000, POKEY_BASE=16'h0450, bus-cycle type enum {IDLE, READ, WRITE, DMA}.
//  - Sub-module atari_phase_gen holds pc, phi2 and the boundary/sample/respond strobes.
//    The top holds the transaction registers.
// TESTING
//  1. Cart model returns 8'hA9 at $4000; request read $4000 -> rw=1, halt=1, d_oe=0,
//     rsp_rdata=8'hA9, rsp_valid exactly 15 clks after accept.
//  2. Write $0452 data 8'h3F -> rw=0 for the whole cycle; d_oe=1 for pc 7..14 and next pc 0;
//     d_out=8'h3F; rsp_valid once.
//  3. Two back-to-back DMA reads $8000,$8001 -> halt low for 30 consecutive clks; phi2 toggles at
//     7/8 clk duty; both responses correct.
//  4. No requests for 100 clks -> phi2 period 15, rw=1, halt=1, d_oe=0, rsp_valid never set, a unchanged.
//  5. Assert reset at pc=10 of a write -> d_oe=0, rw=1, phi2=0 immediately; no rsp_valid;
//     the first post-reset accept occurs at pc=14.
//  6. req_dma=1 with req_we=1 to $C000 -> executes as a read: rw=1, halt=0, d_oe=0, data returned.

Source files
------------

// File: rtl/atari_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : atari_bus_pkg
//  Purpose : Shared constants and types for the Atari 7800 cart-bus
//            initiator (phase timing defaults, decode bases, cycle kinds).
//  Ports   : none (package)
//  Revision: 1.0 - initial release
// ============================================================================
package atari_bus_pkg;

  // Default phi2 timing, in system clocks, at 27 MHz (~1.8 MHz bus).
  localparam int PHI2_LOW_CYC_DEF  = 7;
  localparam int PHI2_HIGH_CYC_DEF = 8;
  localparam int SAMPLE_EARLY_DEF  = 1;

  // Decode bases of the cartridge resources exercised by self-test.
  localparam logic [15:0] ROM_BASE   = 16'h4000;
  localparam logic [15:0] POKEY_BASE = 16'h0450;

  // Kind of bus cycle currently on the bus.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DMA   = 2'd3
  } bus_cycle_e;

endpackage : atari_bus_pkg
`default_nettype wire

// File: rtl/atari_phase_gen.sv
`default_nettype none
// ============================================================================
//  Module  : atari_phase_gen
//  Purpose : Free-running bus phase counter. Produces the registered phi2
//            clock and the strobes the transaction logic keys off.
//  Ports   : clk, reset      - system clock, async active-high reset
//            o_phi2          - registered phase-2 clock
//            o_boundary      - high on the last clk of a bus cycle (pc==P-1)
//            o_sample        - high on the clk whose ending edge samples d_in
//            o_hi_next       - next clk lies in the phi2-high window
//  Revision: 1.0 - initial release
// ============================================================================
module atari_phase_gen #(
  parameter int PHI2_LOW_CYC  = 7,
  parameter int PHI2_HIGH_CYC = 8,
  parameter int SAMPLE_EARLY  = 1
) (
  input  logic clk,
  input  logic reset,
  output logic o_phi2,
  output logic o_boundary,
  output logic o_sample,
  output logic o_hi_next
);

  localparam int P    = PHI2_LOW_CYC + PHI2_HIGH_CYC;
  localparam int PC_W = $clog2(P);

  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_next;
  logic            r_phi2;
  logic            w_hi_next;

  always_comb begin
    w_pc_next = (r_pc == PC_W'(P - 1)) ? '0 : r_pc + PC_W'(1);
    // phi2 is computed from the next count and registered so the pin
    // never sees decode glitches.
    w_hi_next = (w_pc_next >= PC_W'(PHI2_LOW_CYC));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc   <= '0;
      r_phi2 <= 1'b0;
    end else begin
      r_pc   <= w_pc_next;
      r_phi2 <= w_hi_next;
    end
  end

  assign o_phi2     = r_phi2;
  assign o_boundary = (r_pc == PC_W'(P - 1));
  assign o_sample   = (r_pc == PC_W'(P - 1 - SAMPLE_EARLY));
  assign o_hi_next  = w_hi_next;

endmodule : atari_phase_gen
`default_nettype wire

// File: rtl/atari_bus_initiator.sv
`default_nettype none
// ============================================================================
//  Module  : atari_bus_initiator
//  Purpose : Atari 7800 CPU/MARIA bus-cycle generator. Converts a
//            request stream into 6502-style cycles on a/d/phi2/rw/halt and
//            reports completion (with read data) on a one-clk strobe.
//  Ports   : clk, reset                 - 27 MHz clock, async active-high reset
//            req_valid/req_ready        - request handshake (ready at pc==P-1)
//            req_addr/req_we/req_wdata  - address, write flag, write data
//            req_dma                    - MARIA DMA read (halt low), forces read
//            rsp_valid/rsp_rdata        - completion pulse and sampled data
//            a, d_out, d_oe, d_in       - address bus, data bus pad controls
//            phi2, rw, halt             - bus clock, read/write, DMA halt (low)
//  Revision: 1.0 - initial release
// ============================================================================
module atari_bus_initiator
  import atari_bus_pkg::*;
#(
  parameter int PHI2_LOW_CYC  = PHI2_LOW_CYC_DEF,
  parameter int PHI2_HIGH_CYC = PHI2_HIGH_CYC_DEF,
  parameter int SAMPLE_EARLY  = SAMPLE_EARLY_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_addr,
  input  logic        req_we,
  input  logic [7:0]  req_wdata,
  input  logic        req_dma,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic [15:0] a,
  output logic [7:0]  d_out,
  output logic        d_oe,
  input  logic [7:0]  d_in,
  output logic        phi2,
  output logic        rw,
  output logic        halt
);

  logic        w_boundary;
  logic        w_sample;
  logic        w_hi_next;
  logic        w_accept;
  bus_cycle_e  w_req_type;

  bus_cycle_e  r_type;
  logic [15:0] r_a;
  logic [7:0]  r_d_out;
  logic        r_d_oe;
  logic        r_rw;
  logic        r_halt;
  logic        r_rsp_valid;
  logic [7:0]  r_rsp_rdata;

  atari_phase_gen #(
    .PHI2_LOW_CYC  (PHI2_LOW_CYC),
    .PHI2_HIGH_CYC (PHI2_HIGH_CYC),
    .SAMPLE_EARLY  (SAMPLE_EARLY)
  ) u_phase (
    .clk        (clk),
    .reset      (reset),
    .o_phi2     (phi2),
    .o_boundary (w_boundary),
    .o_sample   (w_sample),
    .o_hi_next  (w_hi_next)
  );

  assign req_ready = w_boundary & ~reset;
  assign w_accept  = req_valid & req_ready;

  // DMA wins over the write flag: a DMA request is always a read.
  always_comb begin
    w_req_type = READ;
    if (req_dma) begin
      w_req_type = DMA;
    end else if (req_we) begin
      w_req_type = WRITE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_type      <= IDLE;
      r_a         <= 16'h0000;
      r_d_out     <= 8'h00;
      r_d_oe      <= 1'b0;
      r_rw        <= 1'b1;
      r_halt      <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 8'h00;
    end else begin
      // The response is keyed to the cycle type that is still on the bus,
      // so a dropped or idle cycle never produces a strobe.
      r_rsp_valid <= w_sample && (r_type != IDLE);
      if (w_sample && ((r_type == READ) || (r_type == DMA))) begin
        r_rsp_rdata <= d_in;
      end

      if (w_boundary) begin
        // Write data is held one clk into the following cycle.
        r_d_oe <= (r_type == WRITE);
        if (w_accept) begin
          r_type  <= w_req_type;
          r_a     <= req_addr;
          r_d_out <= req_wdata;
          r_rw    <= ~(req_we & ~req_dma);
          r_halt  <= ~req_dma;
        end else begin
          r_type  <= IDLE;
          r_rw    <= 1'b1;
          r_halt  <= 1'b1;
        end
      end else begin
        r_d_oe <= (r_type == WRITE) && w_hi_next;
      end
    end
  end

  assign a         = r_a;
  assign d_out     = r_d_out;
  assign d_oe      = r_d_oe;
  assign rw        = r_rw;
  assign halt      = r_halt;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;

endmodule : atari_bus_initiator
`default_nettype wire

// File: tb/tb_atari_bus_initiator.sv
`default_nettype none
// ============================================================================
//  Module  : tb_atari_bus_initiator
//  Purpose : Self-checking bench for atari_bus_initiator. A cart model
//            answers reads; a cycle-position model predicts every output.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_atari_bus_initiator;
  import atari_bus_pkg::*;

  localparam int P   = PHI2_LOW_CYC_DEF + PHI2_HIGH_CYC_DEF;
  localparam int LOW = PHI2_LOW_CYC_DEF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_addr = 16'h0000;
  logic        req_we = 1'b0;
  logic [7:0]  req_wdata = 8'h00;
  logic        req_dma = 1'b0;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [15:0] a;
  logic [7:0]  d_out;
  logic        d_oe;
  logic [7:0]  d_in;
  logic        phi2;
  logic        rw;
  logic        halt;

  atari_bus_initiator #(
    .PHI2_LOW_CYC  (PHI2_LOW_CYC_DEF),
    .PHI2_HIGH_CYC (PHI2_HIGH_CYC_DEF),
    .SAMPLE_EARLY  (SAMPLE_EARLY_DEF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_we    (req_we),
    .req_wdata (req_wdata),
    .req_dma   (req_dma),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .a         (a),
    .d_out     (d_out),
    .d_oe      (d_oe),
    .d_in      (d_in),
    .phi2      (phi2),
    .rw        (rw),
    .halt      (halt)
  );

  always #5 clk = ~clk;

  // Cartridge model: ROM byte A9 at $4000, address hash elsewhere.
  function automatic logic [7:0] cart(input logic [15:0] ad);
    if (ad == ROM_BASE) return 8'hA9;
    return ad[7:0] ^ ad[15:8] ^ 8'h5A;
  endfunction

  assign d_in = cart(a);

  // Model state: position in bus cycle and what the current/previous
  // cycle is (0 idle, 1 read, 2 write, 3 dma).
  int          k, kind, prevk;
  logic [15:0] m_a;
  logic [7:0]  m_wd, m_rd;
  int          total = 0, bad = 0;
  int          halt_run, halt_max, oe_cnt, rsp_cnt, rises;
  logic        prev_phi2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (pos=%0d)", tag, obs, exp, k);
    end
  endtask

  task automatic model_reset();
    k = 0; kind = 0; prevk = 0;
    m_a = 16'h0000; m_wd = 8'h00; m_rd = 8'h00;
  endtask

  task automatic clr();
    halt_run = 0; halt_max = 0; oe_cnt = 0; rsp_cnt = 0; rises = 0;
    prev_phi2 = phi2;
  endtask

  task automatic check_all();
    chk("phi2",      32'(phi2),      32'(k >= LOW));
    chk("rw",        32'(rw),        32'(kind != 2));
    chk("halt",      32'(halt),      32'(kind != 3));
    chk("d_oe",      32'(d_oe),      32'((kind == 2 && k >= LOW) || (k == 0 && prevk == 2)));
    chk("a",         32'(a),         32'(m_a));
    chk("req_ready", 32'(req_ready), 32'(k == P - 1 && !reset));
    chk("rsp_valid", 32'(rsp_valid), 32'(k == P - 1 && kind != 0));
    chk("rsp_rdata", 32'(rsp_rdata), 32'(m_rd));
    if (kind == 2) chk("d_out", 32'(d_out), 32'(m_wd));
  endtask

  // One clock: drive request, advance model across the edge, check.
  task automatic tick(input logic v, input logic we, input logic dma,
                      input logic [15:0] ad, input logic [7:0] wd);
    req_valid = v; req_we = we; req_dma = dma; req_addr = ad; req_wdata = wd;
    @(posedge clk); #1;
    k = (k + 1) % P;
    if (k == 0) begin
      prevk = kind;
      if (v) begin
        kind = dma ? 3 : (we ? 2 : 1);
        m_a  = ad;
        m_wd = wd;
      end else begin
        kind = 0;
      end
    end
    if (k == P - 1 && (kind == 1 || kind == 3)) m_rd = cart(m_a);
    req_valid = 1'b0;
    check_all();
    if (halt === 1'b0) halt_run++; else halt_run = 0;
    if (halt_run > halt_max) halt_max = halt_run;
    if (d_oe === 1'b1) oe_cnt++;
    if (rsp_valid === 1'b1) rsp_cnt++;
    if (phi2 === 1'b1 && prev_phi2 === 1'b0) rises++;
    prev_phi2 = phi2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
  endtask

  task automatic wait_ready();
    while (k != P - 1) tick(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
  endtask

  initial begin
    int n, gap, sel;
    logic [15:0] ad;

    // Reset values.
    #2 reset = 1'b1;
    #1 model_reset();
    check_all();
    chk("rst_d_out", 32'(d_out), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1 check_all();
    clr();

    // 1: read $4000 returns A9, 15 clks accept-to-response.
    wait_ready();
    tick(1'b1, 1'b0, 1'b0, ROM_BASE, 8'h00);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      idle(1);
      n++;
      if (rsp_valid === 1'b1) break;
    end
    chk("t1_latency", 32'(n + 1), 32'd15);
    chk("t1_rdata", 32'(rsp_rdata), 32'hA9);

    // 2: write $0452 <- 3F: d_oe 8 clks + 1 hold clk, one response.
    wait_ready();
    clr();
    tick(1'b1, 1'b1, 1'b0, 16'h0452, 8'h3F);
    idle(15);
    chk("t2_oe_clks", 32'(oe_cnt), 32'd9);
    chk("t2_rsp_cnt", 32'(rsp_cnt), 32'd1);

    // 3: back-to-back DMA reads keep halt low for 30 clks.
    wait_ready();
    clr();
    tick(1'b1, 1'b0, 1'b1, 16'h8000, 8'h00);
    wait_ready();
    tick(1'b1, 1'b0, 1'b1, 16'h8001, 8'h00);
    wait_ready();
    idle(16);
    chk("t3_halt_run", 32'(halt_max), 32'd30);
    chk("t3_rsp_cnt", 32'(rsp_cnt), 32'd2);

    // 4: 100 idle clks: no responses, 7 phi2 rising edges.
    wait_ready();
    clr();
    idle(100);
    chk("t4_rsp_cnt", 32'(rsp_cnt), 32'd0);
    chk("t4_phi2_rises", 32'(rises), 32'd7);

    // 5: reset at pc=10 of a write; bus idles at once; next accept at pc=14.
    wait_ready();
    tick(1'b1, 1'b1, 1'b0, 16'h0453, 8'hC4);
    while (k != 10) idle(1);
    reset = 1'b1;
    #1 model_reset();
    check_all();
    @(posedge clk); #1;
    check_all();
    @(negedge clk);
    reset = 1'b0;
    #1 check_all();
    clr();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (req_ready === 1'b1) break;
      tick(1'b1, 1'b1, 1'b0, 16'h0453, 8'hC4);
      n++;
    end
    chk("t5_first_ready", 32'(n), 32'd14);
    tick(1'b1, 1'b1, 1'b0, 16'h0453, 8'hC4);
    idle(15);
    chk("t5_rsp_cnt", 32'(rsp_cnt), 32'd1);

    // 6: DMA with write flag executes as a read.
    wait_ready();
    tick(1'b1, 1'b1, 1'b1, 16'hC000, 8'hEE);
    wait_ready();
    chk("t6_rdata", 32'(rsp_rdata), 32'h9A);

    // Random traffic with random gaps (0 = back-to-back).
    for (int t = 0; t < 60; t++) begin
      gap = $urandom_range(0, 2);
      wait_ready();
      for (int g = 0; g < gap; g++) begin
        idle(1);
        wait_ready();
      end
      sel = $urandom_range(0, 3);
      ad  = ($urandom_range(0, 3) == 0) ? ROM_BASE : 16'($urandom);
      if ($urandom_range(0, 5) == 0) ad = POKEY_BASE + 16'($urandom_range(0, 15));
      tick(1'b1, (sel == 1 || sel == 3), (sel >= 2), ad, 8'($urandom));
    end
    idle(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_atari_bus_initiator
`default_nettype wire
